data_mem_ctrl: RTL and testbench

Data-memory controller sitting directly downstream of the pipeline core's memory stage. It consumes the core's data-side request bundle: request, we_re, byte mask, word address and store data. It services the request against an internal byte-lane-masked word SRAM with a programmable number of wait states. It returns a one-cycle valid pulse and load data, which the core's memory stage wraps into the write-back value.

---
 rtl/data_mem_ctrl.sv | 177 +++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: byte-masked word SRAM behind a request/valid handshake with programmable wait states.
// Optional DATA_MEM_STATS_EN adds load_count/store_count completion counters.
module data_mem_ctrl #(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_STATES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        request,
   input  logic        we_re,
   input  logic [3:0]  mask,
   input  logic [31:0] address,
   input  logic [31:0] store_data,
   output logic        valid,
   output logic [31:0] load_data,
   output logic        error
`ifdef DATA_MEM_STATS_EN
  ,output logic [31:0] load_count,
   output logic [31:0] store_count
`endif
);

   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t        state_r;
   state_t        state_nxt_s;
   logic [3:0]    cnt_r;
   logic [3:0]    cnt_nxt_s;

   logic          we_r;
   logic [3:0]    mask_r;
   logic [31:0]   addr_r;
   logic [31:0]   wdata_r;

   logic          valid_r;
   logic          error_r;
   logic [31:0]   load_data_r;

   logic [31:0]   mem_r [DEPTH_WORDS];

   logic          acc_we_s;
   logic [3:0]    acc_mask_s;
   logic [31:0]   acc_addr_s;
   logic [31:0]   acc_wdata_s;
   logic [AW-1:0] acc_idx_s;
   logic          acc_oor_s;
   logic          enter_resp_s;
   logic          mem_we_s;
   logic          unused_s;

`ifdef DATA_MEM_STATS_EN
   logic [31:0]   load_count_r;
   logic [31:0]   store_count_r;
`endif

   // Access fields: live inputs when jumping straight from IDLE to RESP, latched copy otherwise.
   always_comb begin
      if (state_r == ST_IDLE) begin
         acc_we_s    = we_re;
         acc_mask_s  = mask;
         acc_addr_s  = address;
         acc_wdata_s = store_data;
      end else begin
         acc_we_s    = we_r;
         acc_mask_s  = mask_r;
         acc_addr_s  = addr_r;
         acc_wdata_s = wdata_r;
      end
      acc_idx_s    = acc_addr_s[AW+1:2];
      acc_oor_s    = ((acc_addr_s >> (AW + 2)) != 32'd0);
      enter_resp_s = (state_nxt_s == ST_RESP);
      mem_we_s     = enter_resp_s & acc_we_s & ~acc_oor_s;
      unused_s     = ^acc_addr_s[1:0];
   end

   // Next-state and wait-counter logic.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (request) begin
               if (WAIT_STATES > 0) begin
                  state_nxt_s = ST_WAIT;
                  cnt_nxt_s   = 4'(WAIT_STATES - 1);
               end else begin
                  state_nxt_s = ST_RESP;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (cnt_r == 4'd0) begin
               state_nxt_s = ST_RESP;
            end else begin
               cnt_nxt_s = cnt_r - 4'd1;
            end
         end
         ST_RESP: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = 4'd0;
         end
      endcase
   end

   // State, request latch and registered response; the response is produced on the edge entering RESP.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r       <= ST_IDLE;
         cnt_r         <= 4'd0;
         we_r          <= 1'b0;
         mask_r        <= 4'd0;
         addr_r        <= 32'd0;
         wdata_r       <= 32'd0;
         valid_r       <= 1'b0;
         error_r       <= 1'b0;
         load_data_r   <= 32'd0;
`ifdef DATA_MEM_STATS_EN
         load_count_r  <= 32'd0;
         store_count_r <= 32'd0;
`endif
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         if ((state_r == ST_IDLE) && request) begin
            we_r    <= we_re;
            mask_r  <= mask;
            addr_r  <= address;
            wdata_r <= store_data;
         end
         valid_r <= enter_resp_s;
         error_r <= enter_resp_s & acc_oor_s;
         if (enter_resp_s && !acc_we_s) begin
            load_data_r <= acc_oor_s ? 32'd0 : mem_r[acc_idx_s];
         end
`ifdef DATA_MEM_STATS_EN
         if (enter_resp_s && !acc_oor_s) begin
            if (acc_we_s) begin
               store_count_r <= store_count_r + 32'd1;
            end else begin
               load_count_r  <= load_count_r + 32'd1;
            end
         end
`endif
      end
   end

   // Byte-lane masked array write; gated by rst so an aborted store never lands.
   always_ff @(posedge clk) begin
      if (mem_we_s && rst) begin
         for (int i = 0; i < 4; i++) begin
            if (acc_mask_s[i]) begin
               mem_r[acc_idx_s][8*i +: 8] <= acc_wdata_s[8*i +: 8];
            end
         end
      end
   end

   assign valid     = valid_r;
   assign error     = error_r;
   assign load_data = load_data_r;
`ifdef DATA_MEM_STATS_EN
   assign load_count  = load_count_r;
   assign store_count = store_count_r;
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed vector table, reset/back-to-back sequences,
// and randomized traffic against a word-array reference model.
module tb_data_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        request;
   logic        req0;
   logic        we_re;
   logic [3:0]  mask;
   logic [31:0] address;
   logic [31:0] store_data;
   logic        valid, error, valid0, error0;
   logic [31:0] load_data, load_data0;
`ifdef DATA_MEM_STATS_EN
   logic [31:0] lc, sc, lc0, sc0;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   data_mem_ctrl #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) dut (
      .clk(clk), .rst(rst), .request(request), .we_re(we_re), .mask(mask),
      .address(address), .store_data(store_data), .valid(valid),
      .load_data(load_data), .error(error)
`ifdef DATA_MEM_STATS_EN
     ,.load_count(lc), .store_count(sc)
`endif
   );

   data_mem_ctrl #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
      .clk(clk), .rst(rst), .request(req0), .we_re(we_re), .mask(mask),
      .address(address), .store_data(store_data), .valid(valid0),
      .load_data(load_data0), .error(error0)
`ifdef DATA_MEM_STATS_EN
     ,.load_count(lc0), .store_count(sc0)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One complete access on dut (sel=0, 2 wait states) or dut0 (sel=1, no wait states).
   task automatic access(input bit sel, input bit we, input logic [3:0] m, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] ld, output logic er);
      int lat;
      bit seen;
      @(negedge clk);
      if (sel) req0 = 1'b1; else request = 1'b1;
      we_re = we; mask = m; address = a; store_data = d;
      lat = 0;
      seen = 1'b0;
      while (!seen && lat < 40) begin
         @(negedge clk);
         lat++;
         seen = sel ? valid0 : valid;
      end
      request = 1'b0;
      req0    = 1'b0;
      check("latency", 32'(lat), sel ? 32'd1 : 32'd3);
      ld = sel ? load_data0 : load_data;
      er = sel ? error0 : error;
      @(negedge clk);
      check("single_pulse", {31'd0, sel ? valid0 : valid}, 32'd0);
   endtask

   typedef struct {
      bit          we;
      logic [3:0]  m;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] eld;
      bit          eerr;
   } vec_t;

   vec_t        tbl [10];
   logic [31:0] mem_m [16];
   logic [31:0] last_ld;
   logic [31:0] bvals [3];

   initial begin
      logic [31:0] ld, w, a, d;
      logic        er;
      logic [3:0]  m;
      bit          we, oor;
      int          k, got, cyc, last, vcnt;

      tbl[0] = '{1'b1, 4'b1111, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
      tbl[1] = '{1'b0, 4'b1111, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
      tbl[2] = '{1'b1, 4'b0100, 32'h0000_0010, 32'h00AA_0000, 32'hDEAD_BEEF, 1'b0};
      tbl[3] = '{1'b0, 4'b0000, 32'h0000_0010, 32'h0000_0000, 32'hDEAA_BEEF, 1'b0};
      tbl[4] = '{1'b1, 4'b1111, 32'h0000_0FFC, 32'h1234_5678, 32'hDEAA_BEEF, 1'b0};
      tbl[5] = '{1'b0, 4'b1111, 32'h0000_1000, 32'h0000_0000, 32'h0000_0000, 1'b1};
      tbl[6] = '{1'b1, 4'b1111, 32'h0000_1000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
      tbl[7] = '{1'b0, 4'b1111, 32'h0000_0FFC, 32'h0000_0000, 32'h1234_5678, 1'b0};
      tbl[8] = '{1'b1, 4'b0000, 32'h0000_0FFC, 32'h0000_0000, 32'h1234_5678, 1'b0};
      tbl[9] = '{1'b0, 4'b1111, 32'h0000_0FFE, 32'h0000_0000, 32'h1234_5678, 1'b0};

      rst = 1'b0; request = 1'b0; req0 = 1'b0; we_re = 1'b0;
      mask = 4'd0; address = 32'd0; store_data = 32'd0;
      repeat (3) @(negedge clk);
      check("reset valid", {31'd0, valid}, 32'd0);
      check("reset error", {31'd0, error}, 32'd0);
      check("reset load_data", load_data, 32'd0);
      rst = 1'b1;

      for (int i = 0; i < 10; i++) begin
         access(1'b0, tbl[i].we, tbl[i].m, tbl[i].a, tbl[i].d, ld, er);
         check($sformatf("vec%0d load_data", i), ld, tbl[i].eld);
         check($sformatf("vec%0d error", i), {31'd0, er}, {31'd0, tbl[i].eerr});
      end

      // Reset during WAIT of a store aborts it.
      access(1'b0, 1'b1, 4'b1111, 32'h0000_0020, 32'h1111_1111, ld, er);
      @(negedge clk);
      request = 1'b1; we_re = 1'b1; mask = 4'b1111; address = 32'h20; store_data = 32'h2222_2222;
      @(negedge clk);
      rst = 1'b0;
      request = 1'b0;
      vcnt = 0;
      repeat (2) begin
         @(negedge clk);
         if (valid) vcnt++;
      end
      rst = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (valid) vcnt++;
      end
      check("abort no valid", 32'(vcnt), 32'd0);
      check("abort load_data cleared", load_data, 32'd0);
      access(1'b0, 1'b0, 4'b1111, 32'h0000_0020, 32'd0, ld, er);
      check("abort old content", ld, 32'h1111_1111);
      last_ld = 32'h1111_1111;

      // Randomized traffic against the word-array model (words at 0x40..0x7C).
      for (int i = 0; i < 16; i++) begin
         d = $urandom;
         mem_m[i] = d;
         access(1'b0, 1'b1, 4'b1111, 32'h40 + 32'(4 * i), d, ld, er);
      end
      for (int n = 0; n < 150; n++) begin
         we  = 1'($urandom_range(0, 1));
         oor = ($urandom_range(0, 7) == 0);
         k   = $urandom_range(0, 15);
         m   = 4'($urandom_range(0, 15));
         d   = $urandom;
         a   = oor ? (32'h0000_1000 | 32'($urandom)) : (32'h40 + 32'(4 * k) + 32'($urandom_range(0, 3)));
         access(1'b0, we, m, a, d, ld, er);
         if (oor) begin
            if (!we) last_ld = 32'd0;
         end else if (we) begin
            w = mem_m[k];
            for (int b = 0; b < 4; b++) begin
               if (m[b]) w[8*b +: 8] = d[8*b +: 8];
            end
            mem_m[k] = w;
         end else begin
            last_ld = mem_m[k];
         end
         check($sformatf("rnd%0d load_data", n), ld, last_ld);
         check($sformatf("rnd%0d error", n), {31'd0, er}, {31'd0, oor});
      end

      // Back-to-back loads with request held high, no wait states.
      for (int i = 0; i < 3; i++) begin
         bvals[i] = 32'hA000_0000 + 32'(i * 17);
         access(1'b1, 1'b1, 4'b1111, 32'h100 + 32'(4 * i), bvals[i], ld, er);
      end
      @(negedge clk);
      req0 = 1'b1; we_re = 1'b0; mask = 4'b1111; address = 32'h100;
      got = 0; cyc = 0; last = 0;
      while (got < 3 && cyc < 30) begin
         @(negedge clk);
         cyc++;
         if (valid0) begin
            check($sformatf("b2b%0d data", got), load_data0, bvals[got]);
            if (got > 0) check($sformatf("b2b%0d spacing", got), 32'(cyc - last), 32'd2);
            last = cyc;
            got++;
            address = 32'h100 + 32'(4 * got);
         end
      end
      req0 = 1'b0;
      check("b2b count", 32'(got), 32'd3);

`ifdef DATA_MEM_STATS_EN
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("stats reset load", lc, 32'd0);
      check("stats reset store", sc, 32'd0);
      rst = 1'b1;
      access(1'b0, 1'b1, 4'b1111, 32'h200, 32'h5, ld, er);
      access(1'b0, 1'b1, 4'b0011, 32'h204, 32'h6, ld, er);
      access(1'b0, 1'b0, 4'b1111, 32'h200, 32'h0, ld, er);
      access(1'b0, 1'b0, 4'b1111, 32'h204, 32'h0, ld, er);
      access(1'b0, 1'b0, 4'b1111, 32'h200, 32'h0, ld, er);
      access(1'b0, 1'b0, 4'b1111, 32'h4000, 32'h0, ld, er);
      check("stats store_count", sc, 32'd2);
      check("stats load_count", lc, 32'd3);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
